// File: rtl/ternary_weight_loader.sv
`default_nettype none
// ============================================================================
//  Module      : ternary_weight_loader
//  Description : Streams 2-bit ternary weights into a column-major weight
//                register. Define TERNARY_LOADER_DOUBLE_BUFFER_EN to load
//                into a shadow array published on completion.
//  Revision    : 1.0 - initial release
// ============================================================================
module ternary_weight_loader #(
    parameter int IN_LEN  = 16,
    parameter int OUT_LEN = 8,
    parameter int BUS_W   = 8
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           start,
    input  logic [$clog2(IN_LEN)-1:0]      in_len_m1,
    input  logic [$clog2(OUT_LEN)-1:0]     out_len_m1,
    input  logic                           s_valid,
    input  logic [BUS_W-1:0]               s_data,
    output logic                           s_ready,
    output logic [2*IN_LEN*OUT_LEN-1:0]    weights,
    output logic                           busy,
    output logic                           done,
    output logic                           err
);

    localparam int c_LANES = BUS_W / 2;
    localparam int c_IW    = $clog2(IN_LEN);
    localparam int c_OW    = $clog2(OUT_LEN);
    localparam int c_CW    = $clog2(IN_LEN + c_LANES) + 1;
    localparam int c_WW    = 2 * IN_LEN * OUT_LEN;

    localparam logic [c_IW-1:0] c_IN_MAX  = c_IW'(IN_LEN - 1);
    localparam logic [c_OW-1:0] c_OUT_MAX = c_OW'(OUT_LEN - 1);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_CLEAR = 2'd1;
    localparam logic [1:0] c_ST_LOAD  = 2'd2;
    localparam logic [1:0] c_ST_DONE  = 2'd3;

    logic [1:0]      r_state;
    logic [c_IW-1:0] r_in_m1;
    logic [c_OW-1:0] r_out_m1;
    logic [c_OW-1:0] r_row;
    logic [c_CW-1:0] r_col;
    logic            r_err;
    logic [c_WW-1:0] r_weights;

    logic [c_WW-1:0] w_tgt;
    logic [c_WW-1:0] w_tgt_next;
    logic            w_bad;
    logic            w_beat;
    logic            w_row_end;
    logic            w_last;
    logic [c_IW-1:0] w_in_clamp;
    logic [c_OW-1:0] w_out_clamp;

`ifdef TERNARY_LOADER_DOUBLE_BUFFER_EN
    logic [c_WW-1:0] r_shadow;
    assign w_tgt = r_shadow;
`else
    assign w_tgt = r_weights;
`endif

    assign w_in_clamp  = (in_len_m1  > c_IN_MAX)  ? c_IN_MAX  : in_len_m1;
    assign w_out_clamp = (out_len_m1 > c_OUT_MAX) ? c_OUT_MAX : out_len_m1;

    assign w_beat    = (r_state == c_ST_LOAD) && s_valid;
    assign w_row_end = (int'(r_col) + c_LANES) > int'(r_in_m1);
    assign w_last    = w_row_end && (r_row == r_out_m1);

    // Lanes past the active column count are dropped; code 10 lands as zero.
    always_comb begin
        w_tgt_next = w_tgt;
        w_bad      = 1'b0;
        for (int k = 0; k < c_LANES; k++) begin
            if (int'(r_col) + k <= int'(r_in_m1)) begin
                if (s_data[2*k +: 2] == 2'b10) begin
                    w_bad = 1'b1;
                    w_tgt_next[2*((int'(r_col) + k)*OUT_LEN + int'(r_row)) +: 2] = 2'b00;
                end else begin
                    w_tgt_next[2*((int'(r_col) + k)*OUT_LEN + int'(r_row)) +: 2] = s_data[2*k +: 2];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= c_ST_IDLE;
            r_in_m1   <= '0;
            r_out_m1  <= '0;
            r_row     <= '0;
            r_col     <= '0;
            r_err     <= 1'b0;
            r_weights <= '0;
`ifdef TERNARY_LOADER_DOUBLE_BUFFER_EN
            r_shadow  <= '0;
`endif
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (start) begin
                        r_in_m1  <= w_in_clamp;
                        r_out_m1 <= w_out_clamp;
                        r_state  <= c_ST_CLEAR;
                    end
                end
                c_ST_CLEAR: begin
`ifdef TERNARY_LOADER_DOUBLE_BUFFER_EN
                    r_shadow  <= '0;
`else
                    r_weights <= '0;
`endif
                    r_err   <= 1'b0;
                    r_col   <= '0;
                    r_row   <= '0;
                    r_state <= c_ST_LOAD;
                end
                c_ST_LOAD: begin
                    if (w_beat) begin
`ifdef TERNARY_LOADER_DOUBLE_BUFFER_EN
                        r_shadow  <= w_tgt_next;
`else
                        r_weights <= w_tgt_next;
`endif
                        if (w_bad) begin
                            r_err <= 1'b1;
                        end
                        if (w_row_end) begin
                            r_col <= '0;
                            r_row <= w_last ? '0 : r_row + 1'b1;
                        end else begin
                            r_col <= r_col + c_CW'(c_LANES);
                        end
                        if (w_last) begin
                            r_state <= c_ST_DONE;
`ifdef TERNARY_LOADER_DOUBLE_BUFFER_EN
                            // Publish together with the final beat so weights are valid while done is high.
                            r_weights <= w_tgt_next;
`endif
                        end
                    end
                end
                c_ST_DONE: begin
                    r_state <= c_ST_IDLE;
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign weights = r_weights;
    assign err     = r_err;
    assign busy    = (r_state != c_ST_IDLE);
    assign s_ready = (r_state == c_ST_LOAD);
    assign done    = (r_state == c_ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_ternary_weight_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ternary_weight_loader
//  Description : Randomized self-checking bench with a transaction-level
//                model of ternary_weight_loader (honours
//                TERNARY_LOADER_DOUBLE_BUFFER_EN).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ternary_weight_loader;

    localparam int IN_LEN  = 16;
    localparam int OUT_LEN = 8;
    localparam int BUS_W   = 8;
    localparam int LANES   = BUS_W / 2;
    localparam int WW      = 2 * IN_LEN * OUT_LEN;
    localparam int BOUND   = 3000;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 start;
    logic [3:0]           in_len_m1;
    logic [2:0]           out_len_m1;
    logic                 s_valid;
    logic [BUS_W-1:0]     s_data;
    logic                 s_ready;
    logic [WW-1:0]        weights;
    logic                 busy;
    logic                 done;
    logic                 err;

    always #5 clk = ~clk;

    ternary_weight_loader #(
        .IN_LEN (IN_LEN),
        .OUT_LEN(OUT_LEN),
        .BUS_W  (BUS_W)
    ) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .in_len_m1 (in_len_m1),
        .out_len_m1(out_len_m1),
        .s_valid   (s_valid),
        .s_data    (s_data),
        .s_ready   (s_ready),
        .weights   (weights),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    int checks   = 0;
    int failures = 0;

    // Model: phase 0 idle, 1 clear, 2 load, 3 done; weights as a 2-D array.
    int         m_phase  = 0;
    int         m_in     = 0;
    int         m_out    = 0;
    int         m_beat   = 0;
    bit         m_err    = 1'b0;
    bit         m_active = 1'b0;
    logic [1:0] m_vis [IN_LEN][OUT_LEN];
    logic [1:0] m_sh  [IN_LEN][OUT_LEN];

    task automatic chk(input string name, input logic [WW-1:0] act, input logic [WW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [WW-1:0] pack_vis();
        logic [WW-1:0] v;
        v = '0;
        for (int c = 0; c < IN_LEN; c++)
            for (int r = 0; r < OUT_LEN; r++)
                v[2*(c*OUT_LEN + r) +: 2] = m_vis[c][r];
        return v;
    endfunction

    function automatic logic [1:0] dut_w(input int c, input int r);
        return weights[2*(c*OUT_LEN + r) +: 2];
    endfunction

    task automatic model_clear_all();
        for (int c = 0; c < IN_LEN; c++)
            for (int r = 0; r < OUT_LEN; r++) begin
                m_vis[c][r] = 2'b00;
                m_sh[c][r]  = 2'b00;
            end
    endtask

    task automatic model_step();
        int bpr, row, cb, col;
        logic [BUS_W-1:0] d;
        logic [1:0] code, v;
        if (!rst_n) begin
            model_clear_all();
            m_phase = 0;
            m_err   = 1'b0;
            m_beat  = 0;
            return;
        end
        case (m_phase)
            0: if (start) begin
                m_in    = (int'(in_len_m1)  > IN_LEN-1)  ? IN_LEN-1  : int'(in_len_m1);
                m_out   = (int'(out_len_m1) > OUT_LEN-1) ? OUT_LEN-1 : int'(out_len_m1);
                m_phase = 1;
            end
            1: begin
                for (int c = 0; c < IN_LEN; c++)
                    for (int r = 0; r < OUT_LEN; r++) begin
`ifdef TERNARY_LOADER_DOUBLE_BUFFER_EN
                        m_sh[c][r] = 2'b00;
`else
                        m_vis[c][r] = 2'b00;
`endif
                    end
                m_err   = 1'b0;
                m_beat  = 0;
                m_phase = 2;
            end
            2: if (s_valid) begin
                bpr = (m_in + LANES) / LANES;
                row = m_beat / bpr;
                cb  = (m_beat % bpr) * LANES;
                d   = s_data;
                for (int k = 0; k < LANES; k++) begin
                    col = cb + k;
                    if (col <= m_in) begin
                        code = d[2*k +: 2];
                        v    = (code == 2'b10) ? 2'b00 : code;
                        if (code == 2'b10) m_err = 1'b1;
`ifdef TERNARY_LOADER_DOUBLE_BUFFER_EN
                        m_sh[col][row] = v;
`else
                        m_vis[col][row] = v;
`endif
                    end
                end
                m_beat++;
                if (m_beat == bpr * (m_out + 1)) begin
                    m_phase = 3;
`ifdef TERNARY_LOADER_DOUBLE_BUFFER_EN
                    m_vis = m_sh;
`endif
                end
            end
            default: m_phase = 0;
        endcase
    endtask

    always @(negedge clk) begin
        if (m_active) begin
            chk("busy",    WW'(busy),    WW'(m_phase != 0));
            chk("s_ready", WW'(s_ready), WW'(m_phase == 2));
            chk("done",    WW'(done),    WW'(m_phase == 3));
            chk("err",     WW'(err),     WW'(m_err));
            chk("weights", weights,      pack_vis());
        end
    end

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    // Returns early (after a one-cycle reset) when abort_beat is reached.
    task automatic run_load(input int in_m1, input int out_m1, input bit rnd_data,
                            input logic [BUS_W-1:0] fixed, input int vprob,
                            input int abort_beat, input bit noise);
        int cyc;
        in_len_m1  = 4'(in_m1);
        out_len_m1 = 3'(out_m1);
        start      = 1'b1;
        tick();
        start = 1'b0;
        cyc   = 0;
        while (m_phase != 3 && cyc < BOUND) begin
            s_valid = ($urandom_range(99) < vprob);
            s_data  = rnd_data ? BUS_W'($urandom) : fixed;
            if (noise) begin
                start      = 1'($urandom_range(1));
                in_len_m1  = 4'($urandom);
                out_len_m1 = 3'($urandom);
            end
            if (abort_beat >= 0 && m_phase == 2 && m_beat == abort_beat) begin
                rst_n   = 1'b0;
                s_valid = 1'b0;
                start   = 1'b0;
                tick();
                rst_n = 1'b1;
                return;
            end
            tick();
            cyc++;
        end
        s_valid = 1'b0;
        if (cyc >= BOUND) begin
            failures++;
            checks++;
            $display("FAIL load_timeout actual=%0d cycles required=<%0d", cyc, BOUND);
        end
        // Start on the done cycle must be ignored.
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        rst_n      = 1'b0;
        start      = 1'b0;
        in_len_m1  = '0;
        out_len_m1 = '0;
        s_valid    = 1'b0;
        s_data     = '0;
        model_clear_all();
        tick();
        m_active = 1'b1;
        tick();
        rst_n = 1'b1;
        tick();
        chk("reset_weights", weights, '0);
        chk("reset_busy", WW'(busy), '0);

        // Full-size load of 8'h5D: lanes read 01,11,01,01.
        run_load(15, 7, 1'b0, 8'h5D, 100, -1, 1'b0);
        chk("p35_w00",  WW'(dut_w(0, 0)),  WW'(2'b01));
        chk("p35_w10",  WW'(dut_w(1, 0)),  WW'(2'b11));
        chk("p35_w25",  WW'(dut_w(2, 5)),  WW'(2'b01));
        chk("p35_w157", WW'(dut_w(15, 7)), WW'(2'b01));
        chk("p35_err",  WW'(err),          WW'(1'b0));

        // 6x3 load of all -1, issued right after the done cycle.
        run_load(5, 2, 1'b0, 8'hFF, 100, -1, 1'b0);
        chk("p36_w52", WW'(dut_w(5, 2)), WW'(2'b11));
        chk("p36_w00", WW'(dut_w(0, 0)), WW'(2'b11));
        chk("p36_w60", WW'(dut_w(6, 0)), WW'(2'b00));
        chk("p36_w03", WW'(dut_w(0, 3)), WW'(2'b00));

        // Illegal code in lane 0.
        run_load(3, 1, 1'b0, 8'h02, 100, -1, 1'b0);
        chk("p37_w00", WW'(dut_w(0, 0)), WW'(2'b00));
        chk("p37_err", WW'(err),         WW'(1'b1));

        // 50% valid with start and length noise while busy.
        run_load(15, 7, 1'b0, 8'h5D, 50, -1, 1'b1);
        chk("p38_w10", WW'(dut_w(1, 0)), WW'(2'b11));

        // Reset after beat 10, then a full reload.
        run_load(15, 7, 1'b1, 8'h00, 100, 10, 1'b0);
        chk("p39_zero", weights, '0);
        tick();
        run_load(15, 7, 1'b0, 8'h5D, 100, -1, 1'b0);
        chk("p39_w157", WW'(dut_w(15, 7)), WW'(2'b01));

        // Random lengths, data (including illegal codes) and valid density.
        for (int i = 0; i < 12; i++) begin
            run_load(int'($urandom_range(15)), int'($urandom_range(7)), 1'b1, 8'h00,
                     int'($urandom_range(30, 100)), -1, 1'($urandom_range(1)));
            repeat ($urandom_range(2)) tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ternary_weight_loader.md
TERNARY_WEIGHT_LOADER -- requirements
Module: ternary_weight_loader

Interface
REQ-001 Parameter IN_LEN, default 16, maximum input (column) count; SHALL be at least 2.
REQ-002 Parameter OUT_LEN, default 8, maximum output (row) count; SHALL be at least 2.
REQ-003 Parameter BUS_W, default 8, stream data width; SHALL be even and at least 2, giving BUS_W/2 weights per beat.
REQ-004 clk  in  1  clock; all state SHALL change on the rising edge.
REQ-005 rst_n  in  1  reset; synchronous, active-low.
REQ-006 start  in  1  pulse that begins a load when the block is idle.
REQ-007 in_len_m1  in  clog2(IN_LEN)  active columns minus 1; sampled on an accepted start.
REQ-008 out_len_m1  in  clog2(OUT_LEN)  active rows minus 1; sampled on an accepted start.
REQ-009 s_valid  in  1  stream beat valid.
REQ-010 s_data  in  BUS_W  beat data; weight k occupies bits [2k+1:2k], with k=0 as the lowest-indexed column.
REQ-011 s_ready  out  1  block accepts a beat; a beat transfers when s_valid and s_ready are both 1.
REQ-012 weights  out  2*IN_LEN*OUT_LEN  signed 2-bit weight W[c][r] at bits [2(c*OUT_LEN+r)+1 : 2(c*OUT_LEN+r)].
REQ-013 busy  out  1  high in every state except IDLE.
REQ-014 done  out  1  one-cycle pulse when a load completes.
REQ-015 err  out  1  sticky illegal-code flag.

Function
REQ-016 The state machine SHALL have the states IDLE, CLEAR, LOAD and DONE.
REQ-017 IDLE->CLEAR on start=1; start SHALL be ignored in every other state.
REQ-018 CLEAR SHALL last one cycle, zero every load-target weight, clear err, and move to LOAD.
REQ-019 s_ready SHALL be 1 only in LOAD.
REQ-020 Load order: row r=0..out_len_m1; within a row, beats cover columns in ascending order, BUS_W/2 per beat.
REQ-021 Beats per row SHALL be ceil((in_len_m1+1)/(BUS_W/2)); lanes beyond in_len_m1 in the final beat SHALL be ignored.
REQ-022 Columns above in_len_m1 and rows above out_len_m1 SHALL remain 2'b00 (zero), never undefined.
REQ-023 Codes 00, 01 and 11 SHALL be stored as-is (0, +1, -1); the illegal code 10 SHALL be stored as 00 and set err.
REQ-024 A cycle with s_valid=0 in LOAD SHALL stall the load without changing any state.
REQ-025 The handshake of the final beat of the final row SHALL move the block LOAD->DONE.
REQ-026 DONE SHALL assert done for exactly one cycle, then return to IDLE.
REQ-027 Latency: done SHALL be high in the cycle after the final beat transfers.
REQ-028 A start on the done cycle SHALL be ignored; a start on the following cycle (IDLE) SHALL be accepted.
REQ-029 in_len_m1 or out_len_m1 values at or above IN_LEN or OUT_LEN SHALL be clamped to IN_LEN-1 or OUT_LEN-1.

Reset
REQ-030 With rst_n=0: state=IDLE, all weights=0, s_ready=0, busy=0, done=0, err=0, and all counters=0.
REQ-031 Reset asserted mid-load SHALL abandon the load, leaving no partial weights visible, and reach the REQ-030 values the next cycle.

Configuration
REQ-032 Macro TERNARY_LOADER_DOUBLE_BUFFER_EN SHALL select the buffering mode.
REQ-033 With the macro defined: CLEAR and beat writes SHALL target a shadow array, weights SHALL update from the shadow array only in the done cycle, and weights SHALL stay unchanged during a load.
REQ-034 Without the macro: CLEAR and beat writes SHALL target the weights register directly, partial loads SHALL be visible, and no shadow storage SHALL exist.

Verification
REQ-035 Default parameters, start with in_len_m1=15 and out_len_m1=7, 32 beats of 8'h5D -> columns 0..3 of each beat read 01,11,01,01 per group, done one cycle after beat 32, err=0.
REQ-036 in_len_m1=5, out_len_m1=2, 6 beats of 8'hFF -> W[0..5][0..2]=11, all other weights 00, done after beat 6.
REQ-037 One beat carries 8'h02 (lane 0 = code 10) -> that weight is 00, err=1 until the next accepted start.
REQ-038 s_valid toggled randomly 50% over the REQ-035 load -> same final weights, s_ready low outside LOAD, start during busy ignored.
REQ-039 rst_n=0 after beat 10 of 32, then a full reload -> weights all 0 right after reset, final weights correct after the reload.
REQ-040 Macro defined: weights keep their previous values through the whole load and change only in the done cycle; macro undefined: weights zero in the cycle after CLEAR and fill beat by beat.
